// File: rtl/pkt_serializer.sv
// Packet serializer: pops 10-bit words from an upstream FIFO and sends each as a framed
// serial bit stream (start, 10 data bits LSB first, optional even parity, stop). Parity via `PARITY_EN.
module pkt_serializer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pkt_i,
    input  logic       empty,
    output logic       re,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0]    IDX_LAST = 4'd9;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]    state_r, state_s;
    logic [CW-1:0] cnt_r,   cnt_s;
    logic [3:0]    idx_r,   idx_s;
    logic [9:0]    shreg_r, shreg_s;
    logic          txd_r,   txd_s;
    logic          busy_r,  busy_s;
    logic          done_r,  done_s;
    logic          re_s;
    logic          bit_end_s;
`ifdef PARITY_EN
    logic          parity_r, parity_s;

    // Even parity over a latched word: the parity bit makes the total count of ones even.
    function automatic logic parity10(input logic [9:0] word);
        return ^word;
    endfunction
`endif

    // Next-state, counter and shift-register logic of the framing FSM.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        shreg_s   = shreg_r;
        re_s      = 1'b0;
        bit_end_s = (cnt_r == CNT_MAX);
`ifdef PARITY_EN
        parity_s  = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (!empty && !rst) begin
                    re_s    = 1'b1;
                    shreg_s = pkt_i;
                    cnt_s   = CNT_ZERO;
                    idx_s   = 4'd0;
`ifdef PARITY_EN
                    parity_s = parity10(pkt_i);
`endif
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    cnt_s   = CNT_ZERO;
                    state_s = ST_DATA;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_s = CNT_ZERO;
                    if (idx_r == IDX_LAST) begin
`ifdef PARITY_EN
                        state_s = ST_PARITY;
`else
                        state_s = ST_STOP;
`endif
                    end else begin
                        // The line always carries shreg[0], so advancing is a right shift.
                        idx_s   = idx_r + 4'd1;
                        shreg_s = {1'b0, shreg_r[9:1]};
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
`ifdef PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    cnt_s   = CNT_ZERO;
                    state_s = ST_STOP;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    cnt_s   = CNT_ZERO;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                idx_s   = 4'd0;
                shreg_s = 10'd0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the pins are registers.
    always_comb begin
        txd_s  = 1'b1;
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_STOP) && (cnt_s == CNT_MAX);
        case (state_s)
            ST_IDLE:   txd_s = 1'b1;
            ST_START:  txd_s = 1'b0;
            ST_DATA:   txd_s = shreg_s[0];
`ifdef PARITY_EN
            ST_PARITY: txd_s = parity_s;
`endif
            ST_STOP:   txd_s = 1'b1;
            default:   txd_s = 1'b1;
        endcase
    end

    // State and output registers with synchronous reset; reset drops any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= 4'd0;
            shreg_r <= 10'd0;
            txd_r   <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shreg_r <= shreg_s;
            txd_r   <= txd_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

`ifdef PARITY_EN
    // Parity of the accepted word, captured alongside the shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= parity_s;
        end
    end
`endif

    assign re   = re_s;
    assign txd  = txd_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_pkt_serializer.sv
// Directed bench for pkt_serializer: frame waveform, idle behaviour, back-to-back
// frames, mid-frame reset and input changes during a frame. Honours `PARITY_EN.
module tb_pkt_serializer;

    localparam int CPB = 4;
`ifdef PARITY_EN
    localparam int NBITS = 13;
`else
    localparam int NBITS = 12;
`endif
    localparam int FRAME = CPB * NBITS;

    logic       clk = 1'b0;
    logic       rst;
    logic       empty;
    logic [9:0] pkt_i;
    logic       re, txd, busy, done;
    int         total;
    int         bad;

    pkt_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst  (rst),
        .pkt_i(pkt_i),
        .empty(empty),
        .re   (re),
        .txd  (txd),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Expected line level in frame cycle c (1 = first start-bit cycle).
    function automatic logic exp_txd(input logic [9:0] w, input int c);
        int b;
        b = (c - 1) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 10) return w[b-1];
`ifdef PARITY_EN
        if (b == 11) return ^w;
`endif
        return 1'b1;
    endfunction

    // Accept cycle: word offered in IDLE, re expected immediately, line still high.
    task automatic accept(input logic [9:0] w);
        tick();
        rst   = 1'b0;
        empty = 1'b0;
        pkt_i = w;
        @(negedge clk);
        check($sformatf("accept %03h {re,txd,busy,done}", w), {re, txd, busy, done}, 4'b1100);
    endtask

    // Frame body; pkt_i is scrambled unless the next word is waiting in the FIFO.
    task automatic body(input logic [9:0] w, input logic nv, input logic [9:0] nw);
        for (int c = 1; c <= FRAME; c++) begin
            tick();
            empty = !nv;
            pkt_i = nv ? nw : 10'($urandom);
            @(negedge clk);
            check($sformatf("frame %03h c%0d {re,txd,busy,done}", w, c),
                  {re, txd, busy, done},
                  {1'b0, exp_txd(w, c), 1'b1, (c == FRAME)});
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            empty = 1'b1;
            pkt_i = 10'($urandom);
            @(negedge clk);
            check($sformatf("idle %0d {re,txd,busy,done}", i), {re, txd, busy, done}, 4'b0100);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        empty = 1'b0;
        pkt_i = 10'h2A5;

        // Reset held with a word available: nothing may be popped.
        repeat (3) tick();
        @(negedge clk);
        check("reset {re,txd,busy,done}", {re, txd, busy, done}, 4'b0100);

        // Single word, re in the first cycle after reset release.
        accept(10'h2A5);
        body(10'h2A5, 1'b0, 10'h000);

        idle_check(100);

        // Back-to-back: second accept lands 49 cycles after the first.
        accept(10'h000);
        body(10'h000, 1'b1, 10'h3FF);
        accept(10'h3FF);
        body(10'h3FF, 1'b0, 10'h000);
        idle_check(3);

        // Reset in frame cycle 20 with the FIFO still non-empty.
        accept(10'h155);
        for (int c = 1; c < 20; c++) begin
            tick();
            empty = 1'b0;
            pkt_i = 10'h0CA;
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("pre-abort {re,txd,busy,done}", {re, txd, busy, done},
              {1'b0, exp_txd(10'h155, 20), 1'b1, 1'b0});
        tick();
        rst   = 1'b0;
        empty = 1'b0;
        pkt_i = 10'h0CA;
        @(negedge clk);
        check("post-reset accept {re,txd,busy,done}", {re, txd, busy, done}, 4'b1100);
        body(10'h0CA, 1'b0, 10'h000);

        accept(10'h1B3);
        body(10'h1B3, 1'b0, 10'h000);
        idle_check(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pkt_serializer.md
PKT_SERIALIZER -- requirements
Module: pkt_serializer

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 4, clock cycles per serial bit time (legal range 2..1023).
REQ-002 SHALL have port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: pkt_i  input  10  word presented by the upstream packet FIFO; valid combinationally whenever empty=0.
REQ-005 SHALL have port: empty  input  1  upstream FIFO empty flag.
REQ-006 SHALL have port: re  output  1  pop strobe to the upstream FIFO; a one-cycle pulse per accepted word.
REQ-007 SHALL have port: txd  output  1  serial line; idle high.
REQ-008 SHALL have port: busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-009 SHALL have port: done  output  1  one-cycle pulse in the last cycle of each frame's stop bit.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-011 IDLE: when empty=0, SHALL assert re for exactly that cycle, register pkt_i into a 10-bit shift register, clear the bit-time and bit-index counters, and go to START on the next edge.
REQ-012 IDLE with empty=1: re SHALL stay 0; state SHALL remain IDLE; txd=1.
REQ-013 re SHALL never be asserted while empty=1 or in any state other than IDLE.
REQ-014 START: txd=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-015 DATA: SHALL send the 10 word bits LSB first, each held for exactly CLKS_PER_BIT cycles; bit index counts 0..9.
REQ-016 After bit 9, SHALL go to PARITY if PARITY_EN is defined, else to STOP.
REQ-017 PARITY: txd = XOR of the 10 latched bits (even parity), held for CLKS_PER_BIT cycles, then go to STOP.
REQ-018 STOP: txd=1 for CLKS_PER_BIT cycles; done=1 in the final cycle; next state IDLE.
REQ-019 Latency: txd SHALL fall in the cycle immediately following the re pulse.
REQ-020 Back-to-back: with the FIFO non-empty, the line SHALL be high for exactly CLKS_PER_BIT+1 cycles between frames (stop bit plus one IDLE accept cycle).
REQ-021 pkt_i changes after the re pulse SHALL NOT affect the frame in progress.
REQ-022 The bit-time counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary.
REQ-023 txd SHALL be driven from a register (glitch-free).
REQ-024 busy SHALL be 1 from the cycle after re through the last STOP cycle inclusive.

Reset
REQ-025 While rst=1, on each edge: state=IDLE, txd=1, re=0, busy=0, done=0, counters=0, shift register=0.
REQ-026 rst asserted mid-frame SHALL abort the frame; txd SHALL be 1 after the reset edge; the popped word is discarded and not re-requested.
REQ-027 In the first cycle after rst deasserts with empty=0, the block SHALL assert re.

Configuration
REQ-028 Macro PARITY_EN: when defined, the PARITY state exists and frames are 13 bit times long; when undefined, PARITY is omitted (no parity logic synthesised) and frames are 12 bit times long.

Verification
REQ-029 CLKS_PER_BIT=4, no PARITY_EN, single word pkt_i=10'h2A5 -> one re pulse; txd = 0 (4 cycles), then 1,0,1,0,0,1,0,1,0,1 (4 cycles each), then 1 (4 cycles); done pulses in frame cycle 48; busy high for 48 cycles.
REQ-030 Same word with PARITY_EN -> parity bit 1 after the data bits; frame lasts 52 cycles; done pulses in cycle 52.
REQ-031 Two words 10'h000 and 10'h3FF queued -> two re pulses spaced 4*12+1=49 cycles apart; txd high for exactly 5 cycles between frames.
REQ-032 empty=1 held for 100 cycles -> re=0, txd=1, busy=0, done=0 throughout.
REQ-033 rst pulsed at cycle 20 of a frame with empty=0 -> txd=1 and busy=0 after the reset edge; re asserted in the first cycle after rst drops; new frame starts with a start bit.
REQ-034 pkt_i toggled randomly while busy=1 -> serial data matches the value latched at re.
